// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if
//   Request/result bundle between two requesters and the shared
//   binary-to-BCD engine.
//   Requester side : req0/bin0, req1/bin1 (level request, operand held while req high)
//   Engine side    : gnt0/gnt1 (accept pulses), busy, valid + valid_id (result pulse),
//                    thousands/hundreds/tens/ones (BCD result, held until next valid)
//   master = requester/display side, slave = engine.
interface bcd_conv_arbiter_if #(
  parameter int WIDTH = 12
);
  logic             req0;
  logic [WIDTH-1:0] bin0;
  logic             req1;
  logic [WIDTH-1:0] bin1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             valid;
  logic             valid_id;
  logic [3:0]       thousands;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;

  modport master (
    output req0, bin0, req1, bin1,
    input  gnt0, gnt1, busy, valid, valid_id, thousands, hundreds, tens, ones
  );

  modport slave (
    input  req0, bin0, req1, bin1,
    output gnt0, gnt1, busy, valid, valid_id, thousands, hundreds, tens, ones
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Sequential double-dabble binary-to-BCD converter shared by two requesters
//   through a round-robin arbiter. One add-3/shift iteration per clock; the
//   four-digit result appears with a one-cycle valid pulse tagged by requester.
//   WIDTH must be 1..13 so the result fits in four BCD digits.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous, active-high
//   bus   - slave side of bcd_conv_arbiter_if (requests, grants, result)
module bcd_conv_arbiter #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               reset,
  bcd_conv_arbiter_if.slave  bus
);
  localparam int         SW       = WIDTH + 16;
  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sreg, sreg_nxt, adj, shifted;
  logic [3:0]      cnt, cnt_nxt;
  logic            id, id_nxt;        // owner of the job in flight
  logic            last, last_nxt;    // requester granted most recently
  logic            sel;
  logic            gnt0, gnt0_nxt, gnt1, gnt1_nxt;
  logic            busy, busy_nxt, valid, valid_nxt;
  logic            valid_id, valid_id_nxt;
  logic [15:0]     digits, digits_nxt;

  // Add-3 correction on all four BCD nibbles (sitting above the binary part),
  // then one left shift.
  always_comb begin
    adj = sreg;
    for (int i = 0; i < 4; i++) begin
      if (adj[WIDTH + 4*i +: 4] >= 4'd5)
        adj[WIDTH + 4*i +: 4] = adj[WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {adj[SW-2:0], 1'b0};

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    sreg_nxt     = sreg;
    cnt_nxt      = cnt;
    id_nxt       = id;
    last_nxt     = last;
    sel          = 1'b0;
    gnt0_nxt     = 1'b0;
    gnt1_nxt     = 1'b0;
    busy_nxt     = busy;
    valid_nxt    = 1'b0;
    valid_id_nxt = valid_id;
    digits_nxt   = digits;

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Lone requester wins outright; on a tie the one not served last wins.
          sel       = (bus.req0 && bus.req1) ? ~last : bus.req1;
          sreg_nxt  = {16'b0, (sel ? bus.bin1 : bus.bin0)};
          cnt_nxt   = 4'd0;
          id_nxt    = sel;
          last_nxt  = sel;
          gnt0_nxt  = ~sel;
          gnt1_nxt  = sel;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sreg_nxt = shifted;
        cnt_nxt  = cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          digits_nxt   = shifted[SW-1 -: 16];
          valid_nxt    = 1'b1;
          valid_id_nxt = id;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= 4'd0;
      id       <= 1'b0;
      last     <= 1'b1;   // makes req0 win the first tie
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      valid_id <= 1'b0;
      digits   <= 16'd0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      cnt      <= cnt_nxt;
      id       <= id_nxt;
      last     <= last_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      busy     <= busy_nxt;
      valid    <= valid_nxt;
      valid_id <= valid_id_nxt;
      digits   <= digits_nxt;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.busy      = busy;
  assign bus.valid     = valid;
  assign bus.valid_id  = valid_id;
  assign bus.thousands = digits[15:12];
  assign bus.hundreds  = digits[11:8];
  assign bus.tens      = digits[7:4];
  assign bus.ones      = digits[3:0];
endmodule
